// File: rtl/rocket_flight_unit.sv
// rocket_flight_unit: one rocket's launch capture, 1/64-pixel vertical
// motion, border-exit flag and registered rectangle drawing request.
// Ports:
//   clk, resetN (async, active low)
//   isActive, initialX/Y, initialSpeed: launch interface from the controller
//   startOfFrame: one-cycle frame pulse; pixelX/Y: current VGA pixel
//   topLeftX/Y, reachedBorder: position and exit level for the controller
//   drawingRequest, offsetX/Y: registered hit and offset inside the rocket
module rocket_flight_unit #(
  parameter int ROCKET_W = 4,
  parameter int ROCKET_H = 16,
  parameter int TOP_Y    = 0,
  parameter int BOTTOM_Y = 479
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               isActive,
  input  logic signed [10:0] initialX,
  input  logic signed [10:0] initialY,
  input  logic signed [10:0] initialSpeed,
  input  logic               startOfFrame,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               reachedBorder,
  output logic               drawingRequest,
  output logic signed [10:0] offsetX,
  output logic signed [10:0] offsetY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    EXITED = 2'd2
  } state_t;

  localparam logic signed [11:0] TOP_L = 12'(TOP_Y);
  localparam logic signed [11:0] BOT_L = 12'(BOTTOM_Y - ROCKET_H);
  localparam logic signed [11:0] W_L   = 12'(ROCKET_W);
  localparam logic signed [11:0] H_L   = 12'(ROCKET_H);

  state_t              state_q;
  state_t              state_d;
  logic                isActive_d;
  logic                armed;
  logic signed [16:0]  yFp;
  logic signed [10:0]  speedR;
  logic signed [10:0]  xR;

  logic                launch;
  logic                outRange;
  logic                move;
  logic                hit;
  logic signed [11:0]  px;
  logic signed [11:0]  py;
  logic signed [11:0]  tx;
  logic signed [11:0]  ty;

  assign topLeftX      = xR;
  assign topLeftY      = yFp[16:6];
  assign reachedBorder = (state_q == EXITED);

  assign px = {pixelX[10], pixelX};
  assign py = {pixelY[10], pixelY};
  assign tx = {xR[10], xR};
  assign ty = {topLeftY[10], topLeftY};

  // armed blocks a level that was already high when reset released
  assign launch   = isActive && !isActive_d && armed;
  assign outRange = (ty < TOP_L) || (ty > BOT_L);

  // the controller's clear also stops drawing from the very next cycle
  assign hit = (state_q == FLYING) && isActive &&
               (px >= tx) && (px < tx + W_L) &&
               (py >= ty) && (py < ty + H_L);

  always_comb begin
    state_d = state_q;
    move    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = FLYING;
      end
      FLYING: begin
        if (!isActive)    state_d = IDLE;
        else if (outRange) state_d = EXITED;
        else              move = startOfFrame;
      end
      EXITED: begin
        if (!isActive) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      isActive_d     <= 1'b0;
      armed          <= 1'b0;
      xR             <= '0;
      yFp            <= '0;
      speedR         <= '0;
      drawingRequest <= 1'b0;
      offsetX        <= '0;
      offsetY        <= '0;
    end else begin
      isActive_d     <= isActive;
      armed          <= armed | ~isActive;
      drawingRequest <= hit;
      offsetX        <= pixelX - xR;
      offsetY        <= pixelY - topLeftY;
      if (state_q == IDLE && launch) begin
        xR     <= initialX;
        yFp    <= {initialY, 6'b0};
        speedR <= initialSpeed;
      end else if (move) begin
        yFp <= yFp + {{6{speedR[10]}}, speedR};
      end
    end
  end

endmodule
